// File: rtl/bias_buffer_loader.sv
// Write-side loader for the bias buffer: takes a load command, then broadcasts
// each accepted DDR beat to every bank at a common, incrementing address.
//
// state | meaning
// IDLE  | waiting for a load command; cmd_ready high
// LOAD  | accepting DDR beats; one broadcast write per accepted beat
// DRAIN | final write is on the outputs; write enables drop next edge
// DONE  | one-cycle done pulse, then back to IDLE
module bias_buffer_loader #(
  parameter int DDR_BANDWIDTH    = 512,
  parameter int NUM_BANKS        = 64,
  parameter int WRITE_ADDR_WIDTH = 8,
  parameter int NUM_BEATS_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [WRITE_ADDR_WIDTH-1:0]           cmd_base_addr,
  input  logic [NUM_BEATS_WIDTH-1:0]            cmd_num_beats,
  input  logic                                  ddr_data_valid,
  output logic                                  ddr_data_ready,
  input  logic [DDR_BANDWIDTH-1:0]              ddr_data,
  output logic [NUM_BANKS-1:0]                  bs_write_req,
  output logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr,
  output logic [DDR_BANDWIDTH-1:0]              bs_write_data,
  output logic                                  busy,
  output logic                                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state;
  logic [WRITE_ADDR_WIDTH-1:0] addr;
  logic [NUM_BEATS_WIDTH-1:0]  rem;

  // Handshake readies depend on state only, so no input-to-ready path exists.
  assign cmd_ready      = (state == IDLE);
  assign ddr_data_ready = (state == LOAD);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      bs_write_req  <= '0;
      bs_write_addr <= '0;
      bs_write_data <= '0;
      done          <= 1'b0;
    end else begin
      bs_write_req <= '0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr <= cmd_base_addr;
            rem  <= cmd_num_beats;
            if (cmd_num_beats != '0) begin
              state <= LOAD;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ddr_data_valid) begin
            bs_write_data <= ddr_data;
            bs_write_addr <= {NUM_BANKS{addr}};
            bs_write_req  <= '1;
            addr          <= addr + 1'b1;
            rem           <= rem - 1'b1;
            if (rem == NUM_BEATS_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
